fifo_word_packer: RTL and testbench

Read-side consumer for the team's single-clock valid/ready byte FIFO. It pops narrow entries from the FIFO read port and packs them, little-endian, into wide words on a valid/ready output stream. Partial words are emitted on an explicit flush or after an idle timeout. It sits between the FIFO read port and wide datapath consumers such as the CPU load/store bus or DMA.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_word_packer.sv | 148 ++++++++++++++
 tb/tb_fifo_word_packer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the single-clock byte FIFO family.
//   DEF_IN_WIDTH / DEF_RATIO / DEF_TIMEOUT : default widths and idle timeout
//   clog2()                                : ceiling log2, clog2(1) == 0
//   lane_cnt_t                             : lane count (0..RATIO) at defaults
package fifo_pkg;

    localparam int unsigned DEF_IN_WIDTH = 8;
    localparam int unsigned DEF_RATIO    = 4;
    localparam int unsigned DEF_TIMEOUT  = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r++;
        end
        return r;
    endfunction

    localparam int unsigned DEF_CNT_W = clog2(DEF_RATIO) + 1;

    typedef logic [DEF_CNT_W-1:0] lane_cnt_t;

endpackage

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops narrow entries from a valid/ready FIFO read port and
// packs them little-endian into wide words on a valid/ready output stream.
// Partial words close on flush or after TIMEOUT idle cycles (0 = no timeout).
//   clk, rst    : clock, synchronous active-high reset
//   fifo_ready  : FIFO head valid;  fifo_data : FIFO head entry
//   fifo_valid  : pop request (pop on fifo_valid && fifo_ready)
//   out_valid / out_ready / out_data / out_count : output word stream,
//                 lane 0 = first entry popped, unused upper lanes read 0
//   flush       : close the current partial word
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter  int unsigned IN_WIDTH  = DEF_IN_WIDTH,
    parameter  int unsigned RATIO     = DEF_RATIO,
    parameter  int unsigned TIMEOUT   = DEF_TIMEOUT,
    localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO,
    localparam int unsigned CNT_W     = clog2(RATIO) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_ready,
    input  logic [IN_WIDTH-1:0]  fifo_data,
    output logic                 fifo_valid,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]     out_count,
    input  logic                 flush
);

    localparam int unsigned IDLE_W = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RATIO);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);
    // Idle counter saturates at the hit value so a timeout that meets a
    // stalled output register stays pending until the transfer happens.
    localparam logic [IDLE_W-1:0] IDLE_SAT = (TIMEOUT == 0) ? '0 : IDLE_W'(TIMEOUT - 1);

    logic [RATIO-1:0][IN_WIDTH-1:0] lanes_q, lanes_d;
    logic [CNT_W-1:0]               acc_cnt_q, acc_cnt_d;
    logic [IDLE_W-1:0]              idle_q, idle_d;
    logic                           flush_pend_q, flush_pend_d;
    logic                           out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]           out_data_q, out_data_d;
    logic [CNT_W-1:0]               out_count_q, out_count_d;

    logic pop, free, close, timeout_hit;
    logic xfer_a, xfer_b, xfer_c, xfer;
    logic [RATIO-1:0][IN_WIDTH-1:0] word;
    logic [CNT_W-1:0]               word_cnt;
    logic [CNT_W-1:0]               wr_idx;

    assign fifo_valid  = !rst && (acc_cnt_q != CNT_FULL);
    assign pop         = fifo_valid && fifo_ready;
    assign free        = !out_valid_q || out_ready;
    assign timeout_hit = (TIMEOUT != 0) && (idle_q == IDLE_SAT) && (acc_cnt_q != '0);
    assign close       = flush_pend_q || flush || timeout_hit;

    assign xfer_a = free && pop && (acc_cnt_q == CNT_LAST);
    assign xfer_b = free && (acc_cnt_q == CNT_FULL);
    assign xfer_c = free && close && !xfer_a && (acc_cnt_q != '0) && (acc_cnt_q != CNT_FULL);
    assign xfer   = xfer_a || xfer_b || xfer_c;

    // A pop that coincides with a close starts the next word in lane 0.
    assign wr_idx = xfer_c ? '0 : acc_cnt_q;

    // Accumulator and idle/flush control.
    always_comb begin
        lanes_d      = lanes_q;
        acc_cnt_d    = acc_cnt_q;
        idle_d       = idle_q;
        flush_pend_d = flush_pend_q;
        word         = '0;
        word_cnt     = xfer_a ? CNT_FULL : acc_cnt_q;

        // Lanes at or above acc_cnt are stale; mask them out of the word.
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (CNT_W'(i) < acc_cnt_q) begin
                word[i] = lanes_q[i];
            end
        end
        if (xfer_a) begin
            word[RATIO-1] = fifo_data;
        end

        for (int unsigned i = 0; i < RATIO; i++) begin
            if (pop && (CNT_W'(i) == wr_idx)) begin
                lanes_d[i] = fifo_data;
            end
        end

        if (xfer) begin
            acc_cnt_d = (xfer_c && pop) ? CNT_W'(1) : '0;
        end else if (pop) begin
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end

        if (pop || xfer || (acc_cnt_q == '0)) begin
            idle_d = '0;
        end else if (idle_q != IDLE_SAT) begin
            idle_d = idle_q + IDLE_W'(1);
        end

        // A flush that cannot close a word this cycle is held, including one
        // arriving with an empty accumulator but a pop that starts a word.
        if (xfer) begin
            flush_pend_d = 1'b0;
        end else if (flush && ((acc_cnt_q != '0) || pop)) begin
            flush_pend_d = 1'b1;
        end
    end

    // Output register.
    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = word;
            out_count_d = word_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lanes_q      <= '0;
            acc_cnt_q    <= '0;
            idle_q       <= '0;
            flush_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_count_q  <= '0;
        end else begin
            lanes_q      <= lanes_d;
            acc_cnt_q    <= acc_cnt_d;
            idle_q       <= idle_d;
            flush_pend_q <= flush_pend_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_count_q  <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
module tb_fifo_word_packer;

    localparam int unsigned IN_W    = 8;
    localparam int unsigned RATIO   = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned OUT_W   = IN_W * RATIO;
    localparam int unsigned CNT_W   = 3;

    logic             clk;
    logic             rst;
    logic             fifo_ready;
    logic [IN_W-1:0]  fifo_data;
    logic             fifo_valid;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             flush;

    fifo_word_packer #(
        .IN_WIDTH (IN_W),
        .RATIO    (RATIO),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_ready (fifo_ready),
        .fifo_data  (fifo_data),
        .fifo_valid (fifo_valid),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .flush      (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    typedef struct {
        logic src_en;
        logic o_rdy;
        logic exp_fv;
        logic exp_ov;
    } vec_t;

    exp_t            sb_q[$];
    logic [IN_W-1:0] src_q[$];
    vec_t            vecs[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   samp_cyc = 0;
    int   last_pop_cyc = 0;
    int   pops = 0;
    logic pop_now;
    logic src_en;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void addv(input logic se, input logic ordy, input logic fv, input logic ov);
        vecs.push_back('{src_en: se, o_rdy: ordy, exp_fv: fv, exp_ov: ov});
    endfunction

    task automatic drive_fifo();
        fifo_ready = src_en && (src_q.size() > 0);
        fifo_data  = (src_q.size() > 0) ? src_q[0] : '0;
    endtask

    task automatic push_seq(input logic [IN_W-1:0] start, input logic [IN_W-1:0] step, input int n);
        logic [IN_W-1:0] b;
        b = start;
        for (int k = 0; k < n; k++) begin
            src_q.push_back(b);
            b = b + step;
        end
        drive_fifo();
    endtask

    task automatic expect_word(input logic [OUT_W-1:0] d, input logic [CNT_W-1:0] c);
        sb_q.push_back('{data: d, cnt: c});
    endtask

    // One clock: sample at the falling edge, advance the FIFO model just after
    // the rising edge.
    task automatic cycle(output logic s_fv, output logic s_ov);
        exp_t e;
        @(negedge clk);
        s_fv     = fifo_valid;
        s_ov     = out_valid;
        samp_cyc = cyc;
        pop_now  = fifo_valid && fifo_ready;
        if (pop_now) last_pop_cyc = cyc;
        if (out_valid && !rst) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%0h count %0d, expected none", out_data, out_count);
            end else begin
                e = sb_q[0];
                chk("sb_data", 64'(out_data), 64'(e.data));
                chk("sb_count", 64'(out_count), 64'(e.cnt));
                if (out_ready) void'(sb_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
        if (pop_now) begin
            void'(src_q.pop_front());
            pops++;
        end
        cyc++;
        drive_fifo();
    endtask

    task automatic wait_ov(input int max_cyc, output int at);
        logic fv, ov;
        at = -1;
        for (int i = 0; i < max_cyc; i++) begin
            cycle(fv, ov);
            if (ov) begin
                at = samp_cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_ov: out_valid not seen within %0d cycles, expected it", max_cyc);
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        logic fv, ov;
        for (int i = lo; i <= hi; i++) begin
            src_en    = vecs[i].src_en;
            out_ready = vecs[i].o_rdy;
            drive_fifo();
            cycle(fv, ov);
            chk($sformatf("row%0d_fifo_valid", i), 64'(fv), 64'(vecs[i].exp_fv));
            chk($sformatf("row%0d_out_valid", i), 64'(ov), 64'(vecs[i].exp_ov));
        end
    endtask

    initial begin
        logic fv, ov, any_ov;
        int   at;

        // Streaming rows 0..9: pops 01..08 with a free output.
        repeat (4) addv(1, 1, 1, 0);
        addv(1, 1, 1, 1);
        repeat (3) addv(1, 1, 1, 0);
        addv(1, 1, 1, 1);
        addv(1, 1, 1, 0);
        // Backpressure rows 10..26: 12 bytes, out_ready low for 10 cycles.
        repeat (4) addv(1, 0, 1, 0);
        repeat (4) addv(1, 0, 1, 1);
        repeat (2) addv(1, 0, 0, 1);
        addv(1, 1, 0, 1);
        addv(1, 1, 1, 1);
        repeat (3) addv(1, 1, 1, 0);
        addv(1, 1, 1, 1);
        addv(1, 1, 1, 0);

        rst = 1'b1; out_ready = 1'b1; src_en = 1'b1; flush = 1'b0;
        fifo_ready = 1'b0; fifo_data = '0;

        // Reset.
        repeat (3) cycle(fv, ov);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_fifo_valid", 64'(fifo_valid), 64'd0);
        rst = 1'b0;
        cycle(fv, ov);
        chk("post_rst_fifo_valid", 64'(fv), 64'd1);

        // Streaming.
        push_seq(8'h01, 8'h01, 8);
        expect_word(32'h04030201, 3'd4);
        expect_word(32'h08070605, 3'd4);
        run_rows(0, 9);

        // Backpressure.
        pops = 0;
        push_seq(8'h01, 8'h01, 12);
        expect_word(32'h04030201, 3'd4);
        expect_word(32'h08070605, 3'd4);
        expect_word(32'h0C0B0A09, 3'd4);
        run_rows(10, 19);
        chk("bp_pops_before_stall", 64'(pops), 64'd8);
        run_rows(20, 26);

        // Flush of a 3-byte partial word: transfer on the flush edge.
        push_seq(8'hAA, 8'h11, 3);
        expect_word(32'h00CCBBAA, 3'd3);
        repeat (3) cycle(fv, ov);
        flush = 1'b1;
        cycle(fv, ov);
        flush = 1'b0;
        cycle(fv, ov);
        chk("flush_out_valid", 64'(ov), 64'd1);

        // Flush with an empty accumulator produces nothing.
        flush = 1'b1;
        cycle(fv, ov);
        flush = 1'b0;
        any_ov = ov;
        repeat (4) begin
            cycle(fv, ov);
            any_ov = any_ov | ov;
        end
        chk("flush_empty_no_output", 64'(any_ov), 64'd0);

        // Flush while the output is stalled: held, emitted once free.
        out_ready = 1'b0;
        push_seq(8'h01, 8'h01, 6);
        expect_word(32'h04030201, 3'd4);
        expect_word(32'h00000605, 3'd2);
        repeat (6) cycle(fv, ov);
        flush = 1'b1;
        cycle(fv, ov);
        flush = 1'b0;
        repeat (3) cycle(fv, ov);
        chk("flush_stall_held_valid", 64'(ov), 64'd1);
        out_ready = 1'b1;
        cycle(fv, ov);
        cycle(fv, ov);
        chk("flush_pend_emit", 64'(ov), 64'd1);
        cycle(fv, ov);

        // Timeout: last pop in cycle n -> word loaded on the edge TIMEOUT
        // edges later, first visible in cycle n + TIMEOUT + 1.
        push_seq(8'h11, 8'h11, 2);
        expect_word(32'h00002211, 3'd2);
        wait_ov(40, at);
        chk("timeout_latency", 64'(at - last_pop_cyc), 64'(TIMEOUT + 1));

        // A pop partway through the idle window restarts the count.
        push_seq(8'h33, 8'h00, 1);
        expect_word(32'h00004433, 3'd2);
        cycle(fv, ov);
        any_ov = ov;
        repeat (9) begin
            cycle(fv, ov);
            any_ov = any_ov | ov;
        end
        chk("timeout_no_early_close", 64'(any_ov), 64'd0);
        push_seq(8'h44, 8'h00, 1);
        wait_ov(40, at);
        chk("timeout_restart_latency", 64'(at - last_pop_cyc), 64'(TIMEOUT + 1));
        cycle(fv, ov);

        // Mid-word reset discards the held word and the two-byte partial.
        out_ready = 1'b0;
        push_seq(8'h01, 8'h01, 6);
        expect_word(32'h04030201, 3'd4);
        repeat (8) cycle(fv, ov);
        chk("midrst_pre_out_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        cycle(fv, ov);
        sb_q.delete();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_data", 64'(out_data), 64'd0);
        chk("midrst_out_count", 64'(out_count), 64'd0);
        chk("midrst_fifo_valid", 64'(fifo_valid), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        push_seq(8'h01, 8'h01, 4);
        expect_word(32'h04030201, 3'd4);
        wait_ov(20, at);
        repeat (6) cycle(fv, ov);
        chk("sb_empty_at_end", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
